// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from a registered-output FIFO one at a time
// and serialises each onto a UART TX line as 8N1, 8E1 or 8O1.
// Every output is registered. At most one read enable is issued per frame.
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 868,  // clock cycles per UART bit, >= 2
  parameter int PARITY       = 0     // 0 = none, 1 = even, 2 = odd
) (
  input  logic       i_clk,
  input  logic       i_reset,       // asynchronous, active low
  input  logic       i_fifo_empty,
  input  logic [7:0] i_fifo_data,
  output logic       o_fifo_rd_en,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE_LAST = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BAUD_W-1:0] BAUD_ONE      = BAUD_W'(1);
  localparam bit PARITY_EN  = (PARITY != 0);
  localparam bit PARITY_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic              r_tx;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;

  state_t            w_state;
  logic [BAUD_W-1:0] w_baud;
  logic [2:0]        w_bit_cnt;
  logic [7:0]        w_shift;
  logic              w_parity;
  logic              w_tx;
  logic              w_rd_en;
  logic              w_busy;
  logic              w_done;
  logic              w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Next-state and next-output decode; every output is produced one edge
  // ahead so that the registered versions line up with the bit timing.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state   = r_state;
    w_baud    = r_baud;
    w_bit_cnt = r_bit_cnt;
    w_shift   = r_shift;
    w_parity  = r_parity;
    w_tx      = r_tx;
    w_rd_en   = 1'b0;
    w_busy    = r_busy;
    w_done    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
        if (!i_fifo_empty) begin
          w_rd_en = 1'b1;
          w_busy  = 1'b1;
          w_state = ST_FETCH;
        end
      end

      // The FIFO samples the read enable at the end of this cycle.
      ST_FETCH: begin
        w_state = ST_LATCH;
      end

      // FIFO output is valid now; capture it and start the start bit.
      ST_LATCH: begin
        w_shift   = i_fifo_data;
        w_parity  = (^i_fifo_data) ^ PARITY_ODD;
        w_tx      = 1'b0;
        w_baud    = '0;
        w_bit_cnt = '0;
        w_state   = ST_START;
      end

      ST_START: begin
        if (w_bit_end) begin
          w_tx    = r_shift[0];
          w_shift = {1'b0, r_shift[7:1]};
          w_baud  = '0;
          w_state = ST_DATA;
        end else begin
          w_baud = r_baud + BAUD_ONE;
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_baud = '0;
          if (r_bit_cnt == 3'd7) begin
            if (PARITY_EN) begin
              w_tx    = r_parity;
              w_state = ST_PARITY;
            end else begin
              w_tx    = 1'b1;
              w_state = ST_STOP;
            end
          end else begin
            w_tx      = r_shift[0];
            w_shift   = {1'b0, r_shift[7:1]};
            w_bit_cnt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud = r_baud + BAUD_ONE;
        end
      end

      ST_PARITY: begin
        if (w_bit_end) begin
          w_tx    = 1'b1;
          w_baud  = '0;
          w_state = ST_STOP;
        end else begin
          w_baud = r_baud + BAUD_ONE;
        end
      end

      // Done is raised one edge early so the registered pulse covers the
      // final stop-bit cycle; busy drops together with the return to idle.
      ST_STOP: begin
        if (r_baud == BAUD_PRE_LAST) begin
          w_done = 1'b1;
        end
        if (w_bit_end) begin
          w_baud  = '0;
          w_busy  = 1'b0;
          w_state = ST_IDLE;
        end else begin
          w_baud = r_baud + BAUD_ONE;
        end
      end

      default: begin
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the line idle at once.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values of the previous cycle, independent of statement order.
      r_state   <= w_state;
      r_baud    <= w_baud;
      r_bit_cnt <= w_bit_cnt;
      r_shift   <= w_shift;
      r_parity  <= w_parity;
      r_tx      <= w_tx;
      r_rd_en   <= w_rd_en;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign o_fifo_rd_en = r_rd_en;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Testbench for uart_tx_fifo_drain: four instances (4 clk/bit no parity,
// even, odd, and 868 clk/bit), each fed by a small registered-output FIFO
// model with an underflow flag. Frames are captured bit by bit off o_tx.
module tb_uart_tx_fifo_drain;

  logic       clk;
  logic       rst_n;
  logic       empty [4];
  logic [7:0] din   [4];
  logic       rd_en [4];
  logic       tx    [4];
  logic       busy  [4];
  logic       done  [4];

  // FIFO models
  logic [7:0] mem [4][16];
  int         wp [4] = '{0, 0, 0, 0};
  int         rp [4] = '{0, 0, 0, 0};
  logic [7:0] fdata [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       underflow [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  // Overrides on instance 0 for the mid-frame disturbance test
  logic       ovr_en  = 1'b0;
  logic       ovr_val = 1'b1;
  logic [7:0] xmask   = 8'h00;

  // Event monitors
  int rd_cnt   [4] = '{0, 0, 0, 0};
  int done_cnt [4] = '{0, 0, 0, 0};
  int dbl_rd   [4] = '{0, 0, 0, 0};
  logic rd_prev [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_fifo_empty(empty[0]), .i_fifo_data(din[0]),
    .o_fifo_rd_en(rd_en[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_fifo_empty(empty[1]), .i_fifo_data(din[1]),
    .o_fifo_rd_en(rd_en[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .PARITY(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_fifo_empty(empty[2]), .i_fifo_data(din[2]),
    .o_fifo_rd_en(rd_en[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
  uart_tx_fifo_drain #(.CLKS_PER_BIT(868), .PARITY(0)) u_dut3 (
    .i_clk(clk), .i_reset(rst_n), .i_fifo_empty(empty[3]), .i_fifo_data(din[3]),
    .o_fifo_rd_en(rd_en[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO flags and data as seen by the instances
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      empty[d] = (wp[d] == rp[d]);
      din[d]   = fdata[d];
    end
    if (ovr_en) empty[0] = ovr_val;
    din[0] = fdata[0] ^ xmask;
  end

  // Registered FIFO read port: data valid the cycle after rd_en is sampled
  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rd_en[d]) begin
        if (wp[d] == rp[d]) begin
          underflow[d] <= 1'b1;
        end else begin
          fdata[d] <= mem[d][rp[d] % 16];
          rp[d]    <= rp[d] + 1;
        end
      end
    end
  end

  // Count read enables, done pulses and back-to-back read enables
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rd_en[d] === 1'b1) rd_cnt[d] <= rd_cnt[d] + 1;
      if (done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
      if (rd_en[d] === 1'b1 && rd_prev[d] === 1'b1) dbl_rd[d] <= dbl_rd[d] + 1;
      rd_prev[d] <= rd_en[d];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    mem[d][wp[d] % 16] = b;
    wp[d] = wp[d] + 1;
  endtask

  // Entered at a negedge. Waits for the start bit (counting high gap cycles,
  // busy-low cycles and stray done pulses), then samples nbits*n cycles.
  // Returns at the negedge of the last stop-bit cycle.
  task automatic capture(input int d, input int n, input int nbits,
                         output logic [10:0] bits, output int gap,
                         output int gap_busy_low, output int glitches,
                         output int done_bad, output int busy_bad,
                         output int timeout);
    int c;
    bits = '0; gap = 0; gap_busy_low = 0; glitches = 0;
    done_bad = 0; busy_bad = 0; timeout = 0;
    @(negedge clk);
    c = 0;
    while (tx[d] !== 1'b0) begin
      gap++;
      if (busy[d] !== 1'b1) gap_busy_low++;
      if (done[d] !== 1'b0) done_bad++;
      c++;
      if (c > 100) begin
        timeout = 1;
        return;
      end
      @(negedge clk);
    end
    for (int k = 0; k < nbits * n; k++) begin
      if (k > 0) @(negedge clk);
      if (k % n == 0) bits[k / n] = tx[d];
      else if (tx[d] !== bits[k / n]) glitches++;
      if (busy[d] !== 1'b1) busy_bad++;
      if ((k == nbits * n - 1) ? (done[d] !== 1'b1) : (done[d] !== 1'b0)) done_bad++;
    end
  endtask

  typedef struct {
    int         dut;
    int         n;
    logic [7:0] data;
    int         nbits;
    logic [10:0] exp_bits;  // bit 0 = start bit ... top = stop bit
  } vec_t;

  vec_t       vecs [4];
  logic [10:0] bits;
  int gap, gap_low, glitches, done_bad, busy_bad, timeout, bad, rd0;

  initial begin
    // Hand-computed frames, start bit in bit 0, LSB first
    vecs[0] = '{dut: 0, n: 4,   data: 8'hA5, nbits: 10, exp_bits: 11'h34A};
    vecs[1] = '{dut: 1, n: 4,   data: 8'h07, nbits: 11, exp_bits: 11'h60E};
    vecs[2] = '{dut: 2, n: 4,   data: 8'h07, nbits: 11, exp_bits: 11'h40E};
    vecs[3] = '{dut: 3, n: 868, data: 8'h5B, nbits: 10, exp_bits: 11'h2B6};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++)
      check($sformatf("reset_outputs_dut%0d", d),
            {28'd0, tx[d], busy[d], done[d], rd_en[d]}, 32'h8);
    rst_n = 1'b1;

    // Empty FIFO: nothing must happen for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (rd_en[d] !== 1'b0 || tx[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0) bad++;
    end
    check("idle_while_empty", bad, 0);

    // Single frames from the table
    for (int v = 0; v < 4; v++) begin
      rd0 = rd_cnt[vecs[v].dut];
      push(vecs[v].dut, vecs[v].data);
      capture(vecs[v].dut, vecs[v].n, vecs[v].nbits, bits, gap, gap_low,
              glitches, done_bad, busy_bad, timeout);
      check($sformatf("v%0d_timeout", v), timeout, 0);
      check($sformatf("v%0d_frame_bits", v), bits, vecs[v].exp_bits);
      check($sformatf("v%0d_bit_width", v), glitches, 0);
      check($sformatf("v%0d_done_pulse", v), done_bad, 0);
      check($sformatf("v%0d_busy_in_frame", v), busy_bad, 0);
      check($sformatf("v%0d_latency", v), gap, 2);
      check($sformatf("v%0d_busy_fetch", v), gap_low, 0);
      @(negedge clk);
      check($sformatf("v%0d_idle_after", v),
            {29'd0, tx[vecs[v].dut], busy[vecs[v].dut], done[vecs[v].dut]}, 32'h4);
      check($sformatf("v%0d_rd_pulses", v), rd_cnt[vecs[v].dut] - rd0, 1);
    end

    // Back-to-back drain of three preloaded bytes
    rd0 = rd_cnt[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    for (int f = 0; f < 3; f++) begin
      logic [10:0] exp_b2b [3];
      exp_b2b[0] = 11'h200;
      exp_b2b[1] = 11'h3FE;
      exp_b2b[2] = 11'h278;
      capture(0, 4, 10, bits, gap, gap_low, glitches, done_bad, busy_bad, timeout);
      check($sformatf("b2b%0d_timeout", f), timeout, 0);
      check($sformatf("b2b%0d_frame_bits", f), bits, exp_b2b[f]);
      check($sformatf("b2b%0d_bit_width", f), glitches, 0);
      check($sformatf("b2b%0d_done_pulse", f), done_bad, 0);
      check($sformatf("b2b%0d_busy_in_frame", f), busy_bad, 0);
      check($sformatf("b2b%0d_gap", f), gap, (f == 0) ? 2 : 3);
      check($sformatf("b2b%0d_busy_low_cycles", f), gap_low, (f == 0) ? 0 : 1);
    end
    @(negedge clk);
    check("b2b_rd_pulses", rd_cnt[0] - rd0, 3);

    // Reset during data bit 3 (cycles 16..19 of the frame)
    rd0 = rd_cnt[0];
    push(0, 8'hA5);
    bad = 0;
    while (tx[0] !== 1'b0 && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    check("rst_frame_started", {31'd0, tx[0]}, 0);
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_async_outputs", {28'd0, tx[0], busy[0], done[0], rd_en[0]}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) bad++;
    end
    check("rst_stays_idle", bad, 0);
    check("rst_rd_pulses", rd_cnt[0] - rd0, 1);

    // Empty flag and data disturbed during a frame must not change it
    rd0 = rd_cnt[0];
    push(0, 8'hC3);
    fork
      capture(0, 4, 10, bits, gap, gap_low, glitches, done_bad, busy_bad, timeout);
      begin
        for (int i = 0; i < 100 && tx[0] !== 1'b0; i++) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
          ovr_en  = 1'b1;
          ovr_val = 1'($urandom_range(0, 1));
          xmask   = 8'($urandom);
          @(negedge clk);
        end
        ovr_en = 1'b0;
        xmask  = 8'h00;
      end
    join
    check("dist_timeout", timeout, 0);
    check("dist_frame_bits", bits, 11'h386);
    check("dist_bit_width", glitches, 0);
    check("dist_done_pulse", done_bad, 0);
    @(negedge clk);
    check("dist_rd_pulses", rd_cnt[0] - rd0, 1);

    // Totals and FIFO health
    repeat (5) @(negedge clk);
    check("done_total_dut0", done_cnt[0], 5);
    check("rd_total_dut0", rd_cnt[0], 6);
    for (int d = 1; d < 4; d++) begin
      check($sformatf("done_total_dut%0d", d), done_cnt[d], 1);
      check($sformatf("rd_total_dut%0d", d), rd_cnt[d], 1);
    end
    for (int d = 0; d < 4; d++) begin
      check($sformatf("underflow_dut%0d", d), {31'd0, underflow[d]}, 0);
      check($sformatf("double_rd_dut%0d", d), dbl_rd[d], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Downstream consumer of the bridge's byte FIFO: pops one byte at a time and serialises it onto the UART TX line.
- Frame format: 8N1, or 8E1/8O1 when parity is enabled.
- Sits between the FIFO read side and the UART pin.
- Issues single-cycle read enables only when the FIFO reports non-empty, so the FIFO underflow flag never fires from this block.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal values are ≥ 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_fifo_empty  in  1  FIFO empty flag; 1 = no data.
- i_fifo_data  in  8  FIFO o_data. Registered by the FIFO: valid the cycle after its read enable is sampled.
- o_fifo_rd_en  out  1  FIFO read enable. High for exactly one cycle per byte.
- o_tx  out  1  UART serial output; idle high.
- o_busy  out  1  high while a byte is being fetched or transmitted.
- o_done  out  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Reset (i_reset = 0, asynchronous):
  - o_tx = 1; o_fifo_rd_en = 0; o_busy = 0; o_done = 0.
  - State = IDLE; bit counter, baud counter and shift register = 0.
  - Takes effect immediately, including mid-frame: o_tx returns high at once and the in-flight byte is discarded.
- All outputs are registered.
- States: IDLE, FETCH, LATCH, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx = 1, o_busy = 0.
  - On an edge where i_fifo_empty = 0: o_fifo_rd_en <= 1, o_busy <= 1, go to FETCH.
- FETCH (1 cycle):
  - o_fifo_rd_en <= 0, go to LATCH.
  - The FIFO samples the read enable on this edge and updates i_fifo_data.
- LATCH (1 cycle):
  - shift register <= i_fifo_data.
  - Parity bit <= XOR of the byte (even), or its inverse (odd).
  - o_tx <= 0, go to START, baud counter <= 0.
- START:
  - o_tx = 0 for CLKS_PER_BIT cycles.
  - Then o_tx <= shift[0], go to DATA.
- DATA:
  - 8 bits, LSB first, each bit held CLKS_PER_BIT cycles.
  - Shift right at each bit boundary; bit counter runs 0..7.
  - After bit 7: go to PARITY if PARITY ≠ 0, else STOP.
- PARITY: o_tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - o_tx = 1 for CLKS_PER_BIT cycles.
  - o_done = 1 on the last of those cycles; next state IDLE.
- Baud counter:
  - Width = clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, resets at each bit boundary, wraps with no drift.
- Frame length, start-bit first cycle to stop-bit last cycle:
  - 10·CLKS_PER_BIT cycles with no parity.
  - 11·CLKS_PER_BIT cycles with parity.
- Back-to-back bytes:
  - The IDLE, FETCH and LATCH cycles give a fixed 3-cycle high gap between a stop bit and the next start bit.
  - o_busy drops for exactly the one IDLE cycle.
- i_fifo_empty and i_fifo_data are ignored in every state except IDLE (empty) and LATCH (data). Changes mid-frame have no effect.
- The FIFO becoming empty during FETCH cannot happen: the only reader is this block. No recovery is needed.
- Only one o_fifo_rd_en pulse per frame, ever. A stuck-low i_fifo_empty never yields consecutive read-enable cycles.
- An empty FIFO at reset release: the block stays in IDLE with o_tx = 1 indefinitely.

Test Plan:
- Single byte, no parity:
  - Stimulus: CLKS_PER_BIT = 4, PARITY = 0. Release reset, push 8'hA5, drop empty.
  - Response: one o_fifo_rd_en pulse. o_tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. o_done pulses once; o_busy spans rd_en through the stop bit.
- Back-to-back drain:
  - Stimulus: 3 bytes (8'h00, 8'hFF, 8'h3C) preloaded, CLKS_PER_BIT = 4.
  - Response: three frames of 40 cycles each, separated by exactly 3 idle-high cycles. Exactly three rd_en pulses and three o_done pulses; FIFO underflow stays 0.
- Parity:
  - Stimulus: PARITY = 1 with byte 8'h07, then PARITY = 2 with byte 8'h07.
  - Response: parity bit = 1 (even), then 0 (odd). Frame length is 44 cycles.
- Reset mid-frame:
  - Stimulus: assert i_reset = 0 during DATA bit 3.
  - Response: o_tx, o_busy, o_done and o_fifo_rd_en reach 1/0/0/0 before the next clock edge. After release with the FIFO empty, o_tx stays 1 and no rd_en is issued.
- Empty handling:
  - Stimulus: hold i_fifo_empty = 1 for 100 cycles, then toggle it during a frame.
  - Response: no rd_en while empty. Mid-frame toggles do not alter o_tx timing.
- Large divisor:
  - Stimulus: CLKS_PER_BIT = 868.
  - Response: start-bit low width is exactly 868 cycles; full frame is 8680 cycles.
